// File: rtl/dice_boot_if.sv
// ---------------------------------------------------------------------------
// dice_boot_if
// Bundles the DICE boot sequencer's control/status signals.
//   master : the sequencer (drives engine requests and status outputs)
//   slave  : the environment (boot ROM controller, engines, running stage)
// Signals:
//   start                              ROM controller kicks off the sequence
//   measure_req/ack/err                measurement engine handshake
//   derive_req/ack/err                 CDI KDF handshake
//   lock_req/ack                       secret-lock engine handshake
//   stage_done                         running stage requests handoff
//   stage_idx                          current stage index
//   measurement_done/cdi_derived/prev_secret_locked   per-stage progress flags
//   next_stage_execute                 stage released to execute
//   error_state/err_code               sticky halt and its cause
//   busy/done                          sequencing in progress / completed
// ---------------------------------------------------------------------------
interface dice_boot_if #(
    parameter int NUM_STAGES = 4
);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic          start;
    logic          measure_req;
    logic          measure_ack;
    logic          measure_err;
    logic          derive_req;
    logic          derive_ack;
    logic          derive_err;
    logic          lock_req;
    logic          lock_ack;
    logic          stage_done;
    logic [SW-1:0] stage_idx;
    logic          measurement_done;
    logic          cdi_derived;
    logic          prev_secret_locked;
    logic          next_stage_execute;
    logic          error_state;
    logic [2:0]    err_code;
    logic          busy;
    logic          done;

    modport master (
        input  start, measure_ack, measure_err, derive_ack, derive_err,
               lock_ack, stage_done,
        output measure_req, derive_req, lock_req, stage_idx,
               measurement_done, cdi_derived, prev_secret_locked,
               next_stage_execute, error_state, err_code, busy, done
    );

    modport slave (
        output start, measure_ack, measure_err, derive_ack, derive_err,
               lock_ack, stage_done,
        input  measure_req, derive_req, lock_req, stage_idx,
               measurement_done, cdi_derived, prev_secret_locked,
               next_stage_execute, error_state, err_code, busy, done
    );
endinterface

// File: rtl/dice_boot_sequencer.sv
// ---------------------------------------------------------------------------
// dice_boot_sequencer
// Walks NUM_STAGES DICE boot layers. Each stage runs measure -> CDI derive ->
// previous-secret lock -> execute, with a req/ack handshake per engine and a
// per-phase timeout. Engine errors or timeouts enter a sticky HALT carrying an
// error code; completing the last stage enters a sticky DONE. Both are left
// only through reset.
// Ports:
//   clk    single clock, posedge
//   rst_n  synchronous active-low reset
//   bus    dice_boot_if.master (handshakes, progress flags, status)
// ---------------------------------------------------------------------------
module dice_boot_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    dice_boot_if.master    bus
);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MEASURE, S_DERIVE, S_LOCK, S_EXEC, S_DONE, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_MEASURE    = 3'd1,
        ERR_DERIVE     = 3'd2,
        ERR_MEASURE_TO = 3'd4,
        ERR_DERIVE_TO  = 3'd5,
        ERR_LOCK_TO    = 3'd6
    } err_code_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic            meas_q, meas_d;
    logic            cdi_q, cdi_d;
    logic            lock_q, lock_d;
    err_code_t       err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout;

    // Last permitted cycle of the current handshake phase: req has then been
    // high for TIMEOUT_CYCLES cycles (counts 0..TIMEOUT_CYCLES-1).
    assign timeout = (cnt_q == CNT_LAST);

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        meas_d  = meas_q;
        cdi_d   = cdi_q;
        lock_d  = lock_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_MEASURE;
                    stage_d = '0;
                    meas_d  = 1'b0;
                    cdi_d   = 1'b0;
                    lock_d  = 1'b0;
                    cnt_d   = '0;
                end
            end

            // Priority within a handshake phase: err > ack > timeout.
            S_MEASURE: begin
                if (bus.measure_err) begin
                    state_d = S_HALT;
                    err_d   = ERR_MEASURE;
                end else if (bus.measure_ack) begin
                    state_d = S_DERIVE;
                    meas_d  = 1'b1;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = S_HALT;
                    err_d   = ERR_MEASURE_TO;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            S_DERIVE: begin
                if (bus.derive_err) begin
                    state_d = S_HALT;
                    err_d   = ERR_DERIVE;
                end else if (bus.derive_ack) begin
                    state_d = S_LOCK;
                    cdi_d   = 1'b1;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = S_HALT;
                    err_d   = ERR_DERIVE_TO;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            S_LOCK: begin
                if (bus.lock_ack) begin
                    state_d = S_EXEC;
                    lock_d  = 1'b1;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = S_HALT;
                    err_d   = ERR_LOCK_TO;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            // No timeout while a stage executes; it hands off when ready.
            S_EXEC: begin
                if (bus.stage_done) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MEASURE;
                        stage_d = stage_q + 1'b1;
                        meas_d  = 1'b0;
                        cdi_d   = 1'b0;
                        lock_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end

            // DONE and HALT hold everything (flags stay readable for debug).
            S_DONE, S_HALT: ;

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            meas_q  <= 1'b0;
            cdi_q   <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= ERR_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            meas_q  <= meas_d;
            cdi_q   <= cdi_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs: requests and status follow the registered state, so a
    // reset edge drops every request immediately.
    assign bus.measure_req        = (state_q == S_MEASURE);
    assign bus.derive_req         = (state_q == S_DERIVE);
    assign bus.lock_req           = (state_q == S_LOCK);
    assign bus.next_stage_execute = (state_q == S_EXEC);
    assign bus.done               = (state_q == S_DONE);
    assign bus.error_state        = (state_q == S_HALT);
    assign bus.busy               = (state_q != S_IDLE) && (state_q != S_DONE) &&
                                    (state_q != S_HALT);
    assign bus.stage_idx          = stage_q;
    assign bus.measurement_done   = meas_q;
    assign bus.cdi_derived        = cdi_q;
    assign bus.prev_secret_locked = lock_q;
    assign bus.err_code           = err_q;

endmodule

// File: tb/tb_dice_boot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dice_boot_sequencer
// Directed bench for dice_boot_sequencer with NUM_STAGES=2, TIMEOUT_CYCLES=8.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they show the state entered on that edge.
// ---------------------------------------------------------------------------
module tb_dice_boot_sequencer;
    localparam int NUM_STAGES     = 2;
    localparam int TIMEOUT_CYCLES = 8;

    // Status vector layout:
    // {measure_req, derive_req, lock_req, next_stage_execute, done,
    //  error_state, busy, measurement_done, cdi_derived, prev_secret_locked}
    localparam logic [9:0] ST_IDLE      = 10'b0000000000;
    localparam logic [9:0] ST_MEASURE   = 10'b1000001000;
    localparam logic [9:0] ST_DERIVE    = 10'b0100001100;
    localparam logic [9:0] ST_LOCK      = 10'b0010001110;
    localparam logic [9:0] ST_EXEC      = 10'b0001001111;
    localparam logic [9:0] ST_DONE      = 10'b0000100111;
    localparam logic [9:0] ST_HALT_M    = 10'b0000010000;
    localparam logic [9:0] ST_HALT_MD   = 10'b0000010100;
    localparam logic [9:0] ST_HALT_MDC  = 10'b0000010110;

    logic clk = 1'b0;
    logic rst_n;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    logic nse_prev = 1'b0;

    always #5 clk = ~clk;

    dice_boot_if #(.NUM_STAGES(NUM_STAGES)) bif ();

    dice_boot_sequencer #(
        .NUM_STAGES     (NUM_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.master)
    );

    function automatic logic [9:0] status();
        return {bif.measure_req, bif.derive_req, bif.lock_req,
                bif.next_stage_execute, bif.done, bif.error_state, bif.busy,
                bif.measurement_done, bif.cdi_derived, bif.prev_secret_locked};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Invariants: execute is released only with all three flags set, and
    // never while halted.
    always @(negedge clk) begin
        if (bif.next_stage_execute && !nse_prev)
            check("nse_rise_flags",
                  {29'd0, bif.measurement_done, bif.cdi_derived, bif.prev_secret_locked},
                  32'd7);
        if (bif.error_state)
            check("nse_in_halt", {31'd0, bif.next_stage_execute}, 32'd0);
        nse_prev = bif.next_stage_execute;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n           = 1'b0;
        bif.start       = 1'b0;
        bif.measure_ack = 1'b0;
        bif.measure_err = 1'b0;
        bif.derive_ack  = 1'b0;
        bif.derive_err  = 1'b0;
        bif.lock_ack    = 1'b0;
        bif.stage_done  = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("reset_status", 32'(status()), 32'(ST_IDLE));
        check("reset_stage", 32'(bif.stage_idx), 32'd0);
        check("reset_err", 32'(bif.err_code), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_status", 32'(status()), 32'(ST_IDLE));

        // ---- normal two-stage run, acks one cycle after each req ----
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        check("s0_measure", 32'(status()), 32'(ST_MEASURE));
        check("s0_stage", 32'(bif.stage_idx), 32'd0);
        for (int s = 0; s < NUM_STAGES; s++) begin
            tick();
            bif.measure_ack = 1'b1;
            tick();
            bif.measure_ack = 1'b0;
            check($sformatf("s%0d_derive", s), 32'(status()), 32'(ST_DERIVE));
            tick();
            bif.derive_ack = 1'b1;
            tick();
            bif.derive_ack = 1'b0;
            check($sformatf("s%0d_lock", s), 32'(status()), 32'(ST_LOCK));
            tick();
            bif.lock_ack = 1'b1;
            tick();
            bif.lock_ack = 1'b0;
            check($sformatf("s%0d_exec", s), 32'(status()), 32'(ST_EXEC));
            check($sformatf("s%0d_exec_stage", s), 32'(bif.stage_idx), 32'(s));
            tick();
            tick();
            bif.stage_done = 1'b1;
            tick();
            bif.stage_done = 1'b0;
            if (s == 0) begin
                check("s1_measure", 32'(status()), 32'(ST_MEASURE));
                check("s1_stage", 32'(bif.stage_idx), 32'd1);
            end
        end
        check("run_done", 32'(status()), 32'(ST_DONE));
        check("run_done_err", 32'(bif.err_code), 32'd0);
        // DONE is sticky; start is ignored there.
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        tick();
        check("done_sticky", 32'(status()), 32'(ST_DONE));

        // ---- start ignored in DERIVE, then derive_err ----
        do_reset();
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        bif.measure_ack = 1'b1;
        tick();
        bif.measure_ack = 1'b0;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        check("start_in_derive", 32'(status()), 32'(ST_DERIVE));
        bif.derive_err = 1'b1;
        tick();
        bif.derive_err = 1'b0;
        check("derr_halt", 32'(status()), 32'(ST_HALT_MD));
        check("derr_code", 32'(bif.err_code), 32'd2);
        tick();
        tick();
        check("derr_sticky", 32'(status()), 32'(ST_HALT_MD));

        // ---- measure_err and measure_ack together: error wins ----
        do_reset();
        check("rst_from_halt", 32'(status()), 32'(ST_IDLE));
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        bif.measure_err = 1'b1;
        bif.measure_ack = 1'b1;
        tick();
        bif.measure_err = 1'b0;
        bif.measure_ack = 1'b0;
        check("merr_halt", 32'(status()), 32'(ST_HALT_M));
        check("merr_code", 32'(bif.err_code), 32'd1);

        // ---- lock timeout: lock_req high exactly TIMEOUT_CYCLES cycles ----
        do_reset();
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        bif.measure_ack = 1'b1;
        tick();
        bif.measure_ack = 1'b0;
        bif.derive_ack = 1'b1;
        tick();
        bif.derive_ack = 1'b0;
        n = 0;
        while (bif.lock_req && n < 4 * TIMEOUT_CYCLES) begin
            n++;
            tick();
        end
        check("lock_req_cycles", 32'(n), 32'(TIMEOUT_CYCLES));
        check("lock_to_halt", 32'(status()), 32'(ST_HALT_MDC));
        check("lock_to_code", 32'(bif.err_code), 32'd6);

        // ---- ack on the last allowed cycle wins over the timeout ----
        do_reset();
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        for (int i = 1; i < TIMEOUT_CYCLES; i++) tick();
        check("last_cycle_req", 32'(status()), 32'(ST_MEASURE));
        bif.measure_ack = 1'b1;
        tick();
        bif.measure_ack = 1'b0;
        check("last_cycle_ack", 32'(status()), 32'(ST_DERIVE));
        check("last_cycle_err", 32'(bif.err_code), 32'd0);

        // ---- reset in the middle of stage 1 EXEC ----
        bif.derive_ack = 1'b1;
        tick();
        bif.derive_ack = 1'b0;
        bif.lock_ack = 1'b1;
        tick();
        bif.lock_ack = 1'b0;
        bif.stage_done = 1'b1;
        tick();
        bif.stage_done = 1'b0;
        bif.measure_ack = 1'b1;
        tick();
        bif.measure_ack = 1'b0;
        bif.derive_ack = 1'b1;
        tick();
        bif.derive_ack = 1'b0;
        bif.lock_ack = 1'b1;
        tick();
        bif.lock_ack = 1'b0;
        check("s1_exec_pre_rst", 32'(status()), 32'(ST_EXEC));
        check("s1_exec_stage", 32'(bif.stage_idx), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midexec_rst_status", 32'(status()), 32'(ST_IDLE));
        check("midexec_rst_stage", 32'(bif.stage_idx), 32'd0);
        check("midexec_rst_err", 32'(bif.err_code), 32'd0);
        rst_n = 1'b1;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        check("restart_measure", 32'(status()), 32'(ST_MEASURE));
        check("restart_stage", 32'(bif.stage_idx), 32'd0);

        tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
